// File: rtl/axis_shaper_pkg.sv
// -----------------------------------------------------------------------------
// axis_shaper_pkg
// Shared definitions for the multi-channel AXI-Stream bandwidth shaper.
//   TOKEN_INT_W / TOKEN_FRAC_W : default fixed-point token bucket format
//                                (one token = one byte).
//   MAX_KEEP_W                 : widest tkeep the popcount helper accepts.
//   chan_idx_w()               : bits needed to index NUM_CHANNELS buckets.
//   keep_popcount()            : number of valid bytes in a tkeep word.
// -----------------------------------------------------------------------------
package axis_shaper_pkg;

  localparam int TOKEN_INT_W  = 16;
  localparam int TOKEN_FRAC_W = 8;
  localparam int MAX_KEEP_W   = 128;

  function automatic int unsigned chan_idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Callers zero-extend their tkeep to MAX_KEEP_W; the extra bits count zero.
  function automatic int unsigned keep_popcount(input logic [MAX_KEEP_W-1:0] keep);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      cnt += {31'd0, keep[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/axis_token_bucket.sv
// -----------------------------------------------------------------------------
// axis_token_bucket
// One fixed-point token bucket. Every cycle the bucket gains upd_token_i, loses
// a full MAX_PACKET_LENGTH reservation when debit_i is set, and gains back
// refund_bytes_i when refund_i is set. The three terms are combined in a
// single signed sum, which is then clamped to [0, {max_token_i, FRAC zeros}].
// Ports:
//   aclk, aresetn   : clock, asynchronous active-low reset (bucket -> 0)
//   upd_token_i     : accrual per cycle, 1 integer bit + FRAC_W fraction bits
//   max_token_i     : integer bucket cap
//   debit_i         : charge one packet reservation this cycle
//   refund_i        : return refund_bytes_i whole tokens this cycle
//   refund_bytes_i  : unused part of the reservation, in bytes
//   bucket_o        : current bucket level, INT_W.FRAC_W fixed point
// -----------------------------------------------------------------------------
module axis_token_bucket
  import axis_shaper_pkg::*;
#(
  parameter int INT_W             = TOKEN_INT_W,
  parameter int FRAC_W            = TOKEN_FRAC_W,
  parameter int MAX_PACKET_LENGTH = 1522
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [FRAC_W:0]         upd_token_i,
  input  logic [INT_W-1:0]        max_token_i,
  input  logic                    debit_i,
  input  logic                    refund_i,
  input  logic [INT_W-1:0]        refund_bytes_i,
  output logic [INT_W+FRAC_W-1:0] bucket_o
);

  localparam int BKT_W = INT_W + FRAC_W;
  // Three guard bits: room for bucket + refund + accrual and a sign bit.
  localparam int SUM_W = BKT_W + 3;
  localparam logic [INT_W-1:0] MAX_PKT = INT_W'(MAX_PACKET_LENGTH);

  logic [BKT_W-1:0]        bucket_q, bucket_d;
  logic signed [SUM_W-1:0] bkt_ext, upd_ext, debit_amt, refund_amt, cap, sum;

  // NOTE: every variable written here gets a default at the top so that no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    bkt_ext    = {3'b000, bucket_q};
    upd_ext    = {{(SUM_W-FRAC_W-1){1'b0}}, upd_token_i};
    cap        = {3'b000, max_token_i, {FRAC_W{1'b0}}};
    debit_amt  = '0;
    refund_amt = '0;
    if (debit_i)  debit_amt  = {3'b000, MAX_PKT, {FRAC_W{1'b0}}};
    if (refund_i) refund_amt = {3'b000, refund_bytes_i, {FRAC_W{1'b0}}};

    sum = bkt_ext + upd_ext - debit_amt + refund_amt;

    // The cap check also pulls a bucket down the cycle after the cap is lowered.
    if (sum[SUM_W-1])   bucket_d = '0;
    else if (sum > cap) bucket_d = cap[BKT_W-1:0];
    else                bucket_d = sum[BKT_W-1:0];
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples the pre-edge value of every other register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) bucket_q <= '0;
    else          bucket_q <= bucket_d;
  end

  assign bucket_o = bucket_q;

endmodule

// File: rtl/axi_stream_mc_bw_shaper.sv
// -----------------------------------------------------------------------------
// axi_stream_mc_bw_shaper
// Multi-channel AXI-Stream bandwidth shaper. Data passes straight through;
// only tvalid/tready are gated. A packet may start on channel tdest[CH_W-1:0]
// only when that channel's bucket holds at least MAX_PACKET_LENGTH whole
// tokens (or shaping is disabled for it). The start debits a full
// reservation; the last beat refunds whatever the packet did not use. Once
// started, a packet is never throttled.
// Ports:
//   aclk, aresetn          : clock, asynchronous active-low reset
//   axis_s_*               : upstream slave stream (tdata/tid/tdest/tkeep/
//                            tlast/tvalid in, tready out)
//   axis_m_*               : downstream master stream (outputs, tready in)
//   upd_token              : per-channel accrual per cycle, 1.FRAC fixed point
//   max_token              : per-channel integer bucket cap
//   chan_enable            : per-channel shaping enable
//   stat_throttle_cnt      : per-channel 32-bit count of throttled cycles
// Configuration:
//   AXIS_BW_SHAPER_STATS_EN : when defined, implements the throttle counters;
//                             otherwise stat_throttle_cnt is tied to zero.
// -----------------------------------------------------------------------------
module axi_stream_mc_bw_shaper
  import axis_shaper_pkg::*;
#(
  parameter int AXIS_BUS_WIDTH         = 64,
  parameter int AXIS_ID_WIDTH          = 4,
  parameter int AXIS_DEST_WIDTH        = 4,
  parameter int NUM_CHANNELS           = 4,
  parameter int MAX_PACKET_LENGTH      = 1522,
  parameter int TOKEN_COUNT_INT_WIDTH  = TOKEN_INT_W,
  parameter int TOKEN_COUNT_FRAC_WIDTH = TOKEN_FRAC_W
) (
  input  logic                                            aclk,
  input  logic                                            aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0]                       axis_s_tdata,
  input  logic [AXIS_ID_WIDTH-1:0]                        axis_s_tid,
  input  logic [AXIS_DEST_WIDTH-1:0]                      axis_s_tdest,
  input  logic [AXIS_BUS_WIDTH/8-1:0]                     axis_s_tkeep,
  input  logic                                            axis_s_tlast,
  input  logic                                            axis_s_tvalid,
  output logic                                            axis_s_tready,
  output logic [AXIS_BUS_WIDTH-1:0]                       axis_m_tdata,
  output logic [AXIS_ID_WIDTH-1:0]                        axis_m_tid,
  output logic [AXIS_DEST_WIDTH-1:0]                      axis_m_tdest,
  output logic [AXIS_BUS_WIDTH/8-1:0]                     axis_m_tkeep,
  output logic                                            axis_m_tlast,
  output logic                                            axis_m_tvalid,
  input  logic                                            axis_m_tready,
  input  logic [NUM_CHANNELS*(TOKEN_COUNT_FRAC_WIDTH+1)-1:0] upd_token,
  input  logic [NUM_CHANNELS*TOKEN_COUNT_INT_WIDTH-1:0]   max_token,
  input  logic [NUM_CHANNELS-1:0]                         chan_enable,
  output logic [NUM_CHANNELS*32-1:0]                      stat_throttle_cnt
);

  localparam int INT_W = TOKEN_COUNT_INT_WIDTH;
  localparam int FRAC_W = TOKEN_COUNT_FRAC_WIDTH;
  localparam int BKT_W = INT_W + FRAC_W;
  localparam int CH_W = chan_idx_w(NUM_CHANNELS);
  localparam logic [INT_W-1:0] MAX_PKT = INT_W'(MAX_PACKET_LENGTH);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_IN_PKT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CH_W-1:0]  chan_q, chan_d;
  logic             charged_q, charged_d;
  logic [INT_W-1:0] byte_cnt_q, byte_cnt_d;

  logic [BKT_W-1:0]        bucket [NUM_CHANNELS];
  logic [CH_W-1:0]         head_ch;
  logic                    head_en, head_low, throttle;
  logic                    accept, first_beat, last_beat, pkt_charged;
  logic [INT_W:0]          pkt_bytes;   // one spare bit so the sum cannot wrap
  logic [INT_W-1:0]        used_bytes, refund_bytes;
  logic [NUM_CHANNELS-1:0] debit, refund;

  // Zero-latency sideband pass-through.
  assign axis_m_tdata = axis_s_tdata;
  assign axis_m_tid   = axis_s_tid;
  assign axis_m_tdest = axis_s_tdest;
  assign axis_m_tkeep = axis_s_tkeep;
  assign axis_m_tlast = axis_s_tlast;

  // The channel comes from tdest on the first beat and is held for the rest.
  assign head_ch  = (state_q == S_IN_PKT) ? chan_q : axis_s_tdest[CH_W-1:0];
  assign head_en  = chan_enable[head_ch];
  assign head_low = bucket[head_ch][BKT_W-1:FRAC_W] < MAX_PKT;
  assign throttle = (state_q == S_IDLE) && axis_s_tvalid && head_en && head_low;

  // aresetn is folded in so the handshake drops the moment reset asserts.
  assign axis_m_tvalid = aresetn & axis_s_tvalid & ~throttle;
  assign axis_s_tready = aresetn & axis_m_tready & ~throttle;

  assign accept      = axis_s_tvalid & axis_s_tready;
  assign first_beat  = accept & (state_q == S_IDLE);
  assign last_beat   = accept & axis_s_tlast;
  // A single-beat packet decides chargeability in the same cycle it starts.
  assign pkt_charged = (state_q == S_IDLE) ? head_en : charged_q;

  always_comb begin
    pkt_bytes = (INT_W+1)'(keep_popcount(MAX_KEEP_W'(axis_s_tkeep)));
    if (state_q == S_IN_PKT) pkt_bytes = pkt_bytes + {1'b0, byte_cnt_q};
    used_bytes   = (pkt_bytes > {1'b0, MAX_PKT}) ? MAX_PKT : pkt_bytes[INT_W-1:0];
    refund_bytes = MAX_PKT - used_bytes;

    state_d    = state_q;
    chan_d     = chan_q;
    charged_d  = charged_q;
    byte_cnt_d = byte_cnt_q;
    if (accept) begin
      if (axis_s_tlast) begin
        state_d    = S_IDLE;
        byte_cnt_d = '0;
      end else begin
        state_d    = S_IN_PKT;
        byte_cnt_d = used_bytes;
      end
      if (state_q == S_IDLE) begin
        chan_d    = head_ch;
        charged_d = head_en;
      end
    end
  end

  // Reset mid-packet simply drops the partial packet: no refund is issued.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      chan_q     <= '0;
      charged_q  <= 1'b0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      charged_q  <= charged_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    assign debit[c]  = first_beat && (head_ch == CH_W'(c)) && head_en;
    assign refund[c] = last_beat  && (head_ch == CH_W'(c)) && pkt_charged;

    axis_token_bucket #(
      .INT_W             (INT_W),
      .FRAC_W            (FRAC_W),
      .MAX_PACKET_LENGTH (MAX_PACKET_LENGTH)
    ) u_bucket (
      .aclk           (aclk),
      .aresetn        (aresetn),
      .upd_token_i    (upd_token[c*(FRAC_W+1) +: FRAC_W+1]),
      .max_token_i    (max_token[c*INT_W +: INT_W]),
      .debit_i        (debit[c]),
      .refund_i       (refund[c]),
      .refund_bytes_i (refund_bytes),
      .bucket_o       (bucket[c])
    );

`ifdef AXIS_BW_SHAPER_STATS_EN
    logic [31:0] stat_q;
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) stat_q <= '0;
      else if (throttle && (head_ch == CH_W'(c))) stat_q <= stat_q + 32'd1;
    end
    assign stat_throttle_cnt[c*32 +: 32] = stat_q;
`else
    assign stat_throttle_cnt[c*32 +: 32] = '0;
`endif
  end

endmodule

// File: tb/tb_axi_stream_mc_bw_shaper.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_mc_bw_shaper
// Directed bench for axi_stream_mc_bw_shaper with default parameters
// (64-bit bus, 4 channels, MAX_PACKET_LENGTH 1522, 16.8 token format).
// Combinational gating is exercised from a vector table; bucket arithmetic,
// throttling latency, head-of-line blocking and reset are hand-written
// sequences. Bucket levels are expressed as whole tokens * 256.
// -----------------------------------------------------------------------------
module tb_axi_stream_mc_bw_shaper;

  logic         aclk = 1'b0;
  logic         aresetn;
  logic [63:0]  s_tdata;
  logic [3:0]   s_tid, s_tdest;
  logic [7:0]   s_tkeep;
  logic         s_tlast, s_tvalid, s_tready;
  logic [63:0]  m_tdata;
  logic [3:0]   m_tid, m_tdest;
  logic [7:0]   m_tkeep;
  logic         m_tlast, m_tvalid, m_tready;
  logic [35:0]  upd_token;
  logic [63:0]  max_token;
  logic [3:0]   chan_enable;
  logic [127:0] stat_throttle_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 aclk = ~aclk;

  axi_stream_mc_bw_shaper dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .axis_s_tdata      (s_tdata),
    .axis_s_tid        (s_tid),
    .axis_s_tdest      (s_tdest),
    .axis_s_tkeep      (s_tkeep),
    .axis_s_tlast      (s_tlast),
    .axis_s_tvalid     (s_tvalid),
    .axis_s_tready     (s_tready),
    .axis_m_tdata      (m_tdata),
    .axis_m_tid        (m_tid),
    .axis_m_tdest      (m_tdest),
    .axis_m_tkeep      (m_tkeep),
    .axis_m_tlast      (m_tlast),
    .axis_m_tvalid     (m_tvalid),
    .axis_m_tready     (m_tready),
    .upd_token         (upd_token),
    .max_token         (max_token),
    .chan_enable       (chan_enable),
    .stat_throttle_cnt (stat_throttle_cnt)
  );

  typedef struct {
    logic        valid;
    logic        mready;
    logic [3:0]  dest;
    logic [3:0]  en;
    logic [63:0] data;
    logic        exp_mvalid;
    logic        exp_sready;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] fx(input int tokens);
    return 64'(tokens) * 64'd256;
  endfunction

  function automatic logic [63:0] bkt(input int ch);
    case (ch)
      0:       return 64'(dut.g_chan[0].u_bucket.bucket_q);
      1:       return 64'(dut.g_chan[1].u_bucket.bucket_q);
      2:       return 64'(dut.g_chan[2].u_bucket.bucket_q);
      default: return 64'(dut.g_chan[3].u_bucket.bucket_q);
    endcase
  endfunction

  task automatic set_upd(input int ch, input logic [8:0] v);
    upd_token[ch*9 +: 9] = v;
  endtask

  task automatic set_max(input int ch, input logic [15:0] v);
    max_token[ch*16 +: 16] = v;
  endtask

  task automatic do_reset();
    aresetn     = 1'b0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    s_tkeep     = 8'hFF;
    s_tdest     = 4'd0;
    s_tid       = 4'd0;
    s_tdata     = '0;
    m_tready    = 1'b1;
    upd_token   = '0;
    max_token   = {4{16'd4000}};
    chan_enable = 4'hF;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // One beat that must be accepted at the next rising edge.
  task automatic send_beat(input logic [3:0] dest, input logic [7:0] keep,
                           input logic last, input string name);
    @(negedge aclk);
    s_tvalid = 1'b1;
    s_tdest  = dest;
    s_tkeep  = keep;
    s_tlast  = last;
    s_tdata  = {$urandom, $urandom};
    #1 check({name, "_ready"}, 64'(s_tready), 64'd1);
    @(posedge aclk);
    #1 s_tvalid = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [31:0] exp_stat;

    vecs[0] = '{1'b1, 1'b1, 4'h0, 4'hF, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 4'h1, 4'hF, 64'hDEAD_BEEF_0000_0001, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 4'h1, 4'hF, 64'h1111_2222_3333_4444, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 4'h0, 4'hF, 64'h5555_6666_7777_8888, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 4'h0, 4'hE, 64'h9999_AAAA_BBBB_CCCC, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 4'h5, 4'hF, 64'hFFFF_0000_FFFF_0000, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 4'h4, 4'hF, 64'h0F0F_0F0F_F0F0_F0F0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 4'h2, 4'hF, 64'hA5A5_A5A5_5A5A_5A5A, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 4'h2, 4'hB, 64'h1234_0000_0000_4321, 1'b1, 1'b1};

`ifdef AXIS_BW_SHAPER_STATS_EN
    exp_stat = 32'd1522;
`else
    exp_stat = 32'd0;
`endif

    // Reset state, with a valid beat and ready downstream waiting.
    aresetn = 1'b0;
    s_tvalid = 1'b1; s_tlast = 1'b1; s_tkeep = 8'hFF; s_tdest = 4'd0;
    s_tid = 4'd0; s_tdata = '0; m_tready = 1'b1;
    upd_token = '0; max_token = {4{16'd4000}}; chan_enable = 4'hF;
    #1;
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_stat", stat_throttle_cnt[63:0], 64'd0);
    for (int c = 0; c < 4; c++) check($sformatf("rst_bucket%0d", c), bkt(c), 64'd0);
    check("rst_state", 64'(dut.state_q), 64'd0);

    // Throttle from reset: 1 token/cycle, the beat goes once the bucket hits 1522.
    set_upd(0, 9'h100);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    cnt = 0;
    while (s_tready !== 1'b1 && cnt < 3000) begin
      cnt++;
      @(negedge aclk);
      #1;
    end
    check("thr_gated_cycles", 64'(cnt), 64'd1522);
    check("thr_stat0", 64'(stat_throttle_cnt[31:0]), 64'(exp_stat));
    check("thr_m_tvalid", 64'(m_tvalid), 64'd1);
    @(posedge aclk);
    #1 s_tvalid = 1'b0;
    // 1522 + 1 accrual - 1522 debit + 1514 refund (8-byte single beat).
    check("thr_bucket_after", bkt(0), fx(1515));

    // Idle accrual with saturation and a fractional rate.
    do_reset();
    @(negedge aclk);
    set_upd(2, 9'h100); set_max(2, 16'd3000);
    set_upd(3, 9'h040); set_max(3, 16'd4000);
    repeat (10000) @(posedge aclk);
    @(negedge aclk);
    check("sat_bucket2", bkt(2), fx(3000));
    check("frac_bucket3", bkt(3), fx(2500));
    check("idle_bucket0", bkt(0), 64'd0);

    // Fill ch1 to exactly 2000 by capping it, then freeze it.
    do_reset();
    @(negedge aclk);
    set_upd(1, 9'h100); set_max(1, 16'd2000);
    repeat (2100) @(posedge aclk);
    @(negedge aclk);
    check("fill_bucket1", bkt(1), fx(2000));
    set_upd(1, 9'h000); set_max(1, 16'd4000);

    // 8-beat full packet: debit on beat 1, refund 1522-64 on the last.
    // Beats 2..8 are accepted while the bucket is below 1522.
    for (int i = 0; i < 8; i++) begin
      send_beat(4'd1, 8'hFF, i == 7, $sformatf("p8_beat%0d", i));
      if (i == 0) begin
        check("p8_bucket_first", bkt(1), fx(478));
        check("p8_state_inpkt", 64'(dut.state_q), 64'd1);
      end
    end
    check("p8_bucket_last", bkt(1), fx(1936));
    check("p8_state_idle", 64'(dut.state_q), 64'd0);

    // 3-beat packet with a 4-byte tail: 20 bytes used, 1502 refunded.
    send_beat(4'd1, 8'hFF, 1'b0, "p3_beat0");
    check("p3_bucket_first", bkt(1), fx(414));
    send_beat(4'd1, 8'hFF, 1'b0, "p3_beat1");
    send_beat(4'd1, 8'h0F, 1'b1, "p3_beat2");
    check("p3_bucket_last", bkt(1), fx(1916));

    // Head-of-line: an empty ch0 blocks the stream until ch0 is unshaped.
    @(negedge aclk);
    s_tvalid = 1'b1; s_tdest = 4'd0; s_tkeep = 8'hFF; s_tlast = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("hol_blocked%0d", k), {m_tvalid, s_tready}, 64'd0);
      @(negedge aclk);
    end
    check("hol_bucket1_held", bkt(1), fx(1916));
    chan_enable = 4'hE;
    #1 check("hol_unshaped_pass", {m_tvalid, s_tready}, 64'd3);
    @(posedge aclk);
    #1 s_tvalid = 1'b0;
    chan_enable = 4'hF;
    check("hol_bucket0_unchanged", bkt(0), 64'd0);
    check("hol_single_idle", 64'(dut.state_q), 64'd0);
    send_beat(4'd1, 8'hFF, 1'b1, "hol_ch1");
    check("hol_bucket1_after", bkt(1), fx(1908));

    // Combinational gating table (bucket0=0, bucket1=1908, bucket2=0, idle).
    for (int v = 0; v < 9; v++) begin
      @(negedge aclk);
      s_tvalid    = vecs[v].valid;
      m_tready    = vecs[v].mready;
      s_tdest     = vecs[v].dest;
      chan_enable = vecs[v].en;
      s_tdata     = vecs[v].data;
      s_tlast     = 1'b1;
      #1;
      check($sformatf("vec%0d_m_tvalid", v), 64'(m_tvalid), 64'(vecs[v].exp_mvalid));
      check($sformatf("vec%0d_s_tready", v), 64'(s_tready), 64'(vecs[v].exp_sready));
      check($sformatf("vec%0d_tdata", v), m_tdata, vecs[v].data);
      check($sformatf("vec%0d_tdest", v), 64'(m_tdest), 64'(vecs[v].dest));
      s_tvalid    = 1'b0;
      m_tready    = 1'b1;
      chan_enable = 4'hF;
    end

    // Reset asserted during beat 3 of a 10-beat ch1 packet.
    send_beat(4'd1, 8'hFF, 1'b0, "rmid_beat0");
    send_beat(4'd1, 8'hFF, 1'b0, "rmid_beat1");
    @(negedge aclk);
    s_tvalid = 1'b1; s_tdest = 4'd1; s_tkeep = 8'hFF; s_tlast = 1'b0;
    #1 check("rmid_pre_m_tvalid", 64'(m_tvalid), 64'd1);
    aresetn = 1'b0;
    #1 check("rmid_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rmid_s_tready", 64'(s_tready), 64'd0);
    s_tvalid = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) check($sformatf("rmid_bucket%0d", c), bkt(c), 64'd0);
    check("rmid_state", 64'(dut.state_q), 64'd0);
    check("rmid_byte_cnt", 64'(dut.byte_cnt_q), 64'd0);
    check("rmid_stat", stat_throttle_cnt[63:0], 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
